// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared cache/memory request types and arbiter state encoding
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_LINE_W = 128;

    typedef struct packed {
        logic                  valid;
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_LINE_W-1:0] data;
    } mem_req_type;

    typedef struct packed {
        logic                  ready;
        logic [MEM_LINE_W-1:0] data;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_type;

endpackage

// File: rtl/arb_req_buffer.sv
// rtl/arb_req_buffer.sv - single-entry pending request holder for one cache port
module arb_req_buffer
    import mem_port_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        set,
    input  mem_req_type req_in,
    input  logic        clear,
    output logic        pending,
    output mem_req_type entry,
    output logic        overflow
);

    // A pulse is only an overflow if the held request is not retiring this cycle.
    assign overflow = set && pending && !clear;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
            entry   <= '0;
        end else begin
            if (set && !overflow) begin
                entry <= req_in;
            end
            pending <= set || (pending && !clear);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one backing-memory port between I-cache and D-cache miss handlers
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int LINE_W     = MEM_LINE_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_req_type  ic_req,
    output mem_data_type ic_rsp,
    input  mem_req_type  dc_req,
    output mem_data_type dc_rsp,
    output mem_req_type  mem_req,
    input  mem_data_type mem_rsp,
    output logic         owner,
    output logic         busy,
    output logic         proto_err
);

    if (ADDR_W != MEM_ADDR_W || LINE_W != MEM_LINE_W) begin : g_width_check
        $error("mem_port_arbiter widths must match the cache types package");
    end

    arb_state_type state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic          ic_pending, dc_pending, ic_clear, dc_clear, ic_ovf, dc_ovf;
    logic          complete;
    mem_req_type   ic_entry, dc_entry, owner_entry;

    arb_req_buffer u_ic_buf (
        .clock    (clock),
        .reset    (reset),
        .set      (ic_req.valid),
        .req_in   (ic_req),
        .clear    (ic_clear),
        .pending  (ic_pending),
        .entry    (ic_entry),
        .overflow (ic_ovf)
    );

    arb_req_buffer u_dc_buf (
        .clock    (clock),
        .reset    (reset),
        .set      (dc_req.valid),
        .req_in   (dc_req),
        .clear    (dc_clear),
        .pending  (dc_pending),
        .entry    (dc_entry),
        .overflow (dc_ovf)
    );

    assign owner_entry = owner_q ? dc_entry : ic_entry;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            proto_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            proto_err    <= proto_err || ic_ovf || dc_ovf;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ic_clear     = 1'b0;
        dc_clear     = 1'b0;
        complete     = 1'b0;
        mem_req      = '0;
        ic_rsp       = '0;
        dc_rsp       = '0;

        case (state_q)
            IDLE: begin
                // A stray mem_rsp.ready here is deliberately ignored.
                if (ic_pending || dc_pending) begin
                    if (ic_pending && dc_pending) begin
                        owner_d = (FIXED_PRIO != 0) ? 1'b1 : !last_grant_q;
                    end else begin
                        owner_d = dc_pending;
                    end
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_req       = owner_entry;
                mem_req.valid = 1'b1;
                complete      = mem_rsp.ready;
                state_d       = WAIT;
            end
            WAIT: begin
                mem_req       = owner_entry;
                mem_req.valid = 1'b0;
                complete      = mem_rsp.ready;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
            if (owner_q) begin
                dc_rsp.ready = 1'b1;
                dc_rsp.data  = mem_rsp.data;
                dc_clear     = 1'b1;
            end else begin
                ic_rsp.ready = 1'b1;
                ic_rsp.data  = mem_rsp.data;
                ic_clear     = 1'b1;
            end
        end

        // Keep outputs quiet while reset is held, whatever state is being left.
        if (reset) begin
            mem_req = '0;
            ic_rsp  = '0;
            dc_rsp  = '0;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache and data-cache miss FSMs.
- Each cache issues a one-cycle request pulse (line read or dirty-line write-back), then waits for a ready pulse.
- The arbiter latches each pulse, grants one requester at a time, and drives a one-cycle request to memory. It routes the memory response back to the owning cache only.
- It sits between the two cache controllers and the memory model or controller.

Parameters:
- ADDR_W, 32, address width carried in mem_req_type.addr.
- LINE_W, 128, cache-line width carried in mem_req_type.data and mem_data_type.data.
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = data cache always wins a simultaneous tie.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset for all state.
- ic_req  in  mem_req_type  I-cache request; valid is a one-cycle pulse.
- ic_rsp  out  mem_data_type  response to the I-cache.
- dc_req  in  mem_req_type  D-cache request; valid is a one-cycle pulse.
- dc_rsp  out  mem_data_type  response to the D-cache.
- mem_req  out  mem_req_type  request to memory.
- mem_rsp  in  mem_data_type  memory response; ready is a one-cycle pulse.
- owner  out  1  0 = I-cache, 1 = D-cache; valid while busy.
- busy  out  1  high in GRANT or WAIT.
- proto_err  out  1  sticky flag: a new pulse arrived on a port that already had a pending request.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; both pending bits = 0; last_grant = 1, so the I-cache wins the first round-robin tie.
  - proto_err = 0.
  - mem_req.valid = 0; ic_rsp and dc_rsp = all zero.
- Capture: on a valid pulse, a port's pending bit sets and its addr/data/rw are stored in that port's buffer.
  - Set wins over a same-cycle clear. This covers the D-cache re-issuing its allocate read in the same cycle it receives write-back ready.
- Overflow: a pulse while that port's pending bit is already set and is not being cleared that cycle:
  - the stored request is kept;
  - proto_err sets and stays set until reset.
- State IDLE:
  - If any pending bit is set, choose a port. Round-robin prefers the port that is not last_grant. FIXED_PRIO=1 prefers the D-cache.
  - Latch owner and go to GRANT.
  - A request pulse arriving in IDLE becomes eligible in the next cycle (capture-then-grant, one cycle minimum).
- State GRANT (exactly one cycle):
  - mem_req = owner buffer with valid = 1.
  - If mem_rsp.ready arrives in this same cycle, complete as in WAIT.
  - Otherwise go to WAIT.
- State WAIT:
  - mem_req.valid = 0; mem_req addr/data/rw hold the owner buffer.
  - On mem_rsp.ready:
    - drive the owner's rsp.ready = 1 and rsp.data = mem_rsp.data combinationally in the same cycle;
    - clear the owner's pending bit, unless a new pulse sets it;
    - last_grant = owner; go to IDLE.
- Response ports:
  - The non-owner rsp is always zero.
  - The owner rsp is zero except in the ready cycle.
  - mem_rsp.ready in IDLE (stray or late) is dropped and not forwarded.
- Latency: request pulse to mem_req.valid is 2 cycles when the arbiter is idle (capture, IDLE decision, GRANT). There is no extra latency on the response path.
- Reset mid-transaction:
  - return to IDLE and drop both pending requests;
  - any later mem_rsp.ready for the aborted request is dropped by the IDLE rule.
- Simultaneous pulses on both ports: both are captured; the winner is chosen by the tie rule above, and the loser stays pending.
- No timeout: WAIT is held indefinitely until ready.

Decomposition:
- Shared package (existing cache types package): mem_req_type, mem_data_type, and the arb_state_type enum (IDLE, GRANT, WAIT).
- One sub-module, arb_req_buffer: a single-entry pending register per port, with set-priority-over-clear and an overflow flag. It is instantiated twice.

Test Plan:
- I-cache read pulse addr 0x0000_0040, memory ready 3 cycles after GRANT with data 0x…DEADBEEF -> mem_req.valid high for 1 cycle, 2 cycles after the pulse. ic_rsp.ready is 1 for 1 cycle with that data. dc_rsp stays 0.
- Both caches pulse in the same cycle (ic 0x100 read, dc 0x200 read), FIXED_PRIO=0, after reset -> I-cache is served first, then D-cache. Exactly two mem_req.valid pulses occur, in order 0x100, 0x200.
- D-cache write-back 0x300 rw=1, then same-cycle re-issue of read 0x340 on ready, with the I-cache pending -> I-cache is granted next, then the D-cache read. proto_err stays 0.
- Zero-latency memory (ready in the GRANT cycle) -> the response is forwarded in that cycle and the FSM returns to IDLE with no WAIT cycle.
- Second D-cache pulse while its first request is pending -> the first request is serviced unchanged and proto_err = 1 until reset.
- Reset asserted in WAIT, then a stray mem_rsp.ready -> both rsp ports stay 0, busy = 0, and no new mem_req.valid is issued.
